// File: rtl/zx8302_sertx.sv
// ZX8302 serial transmit stage: TCTRL register, one-byte holding register,
// shift register and baud timing for the SER1/SER2 transmit lines.
module zx8302_sertx #(
  parameter int CLK_HZ = 21000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tctrl_we,
  input  logic [7:0] tctrl_din,
  input  logic       tx_we,
  input  logic [7:0] tx_din,
  input  logic       ser1_dtr,
  input  logic       ser2_cts,
  output logic       tx_full,
  output logic       tx_active,
  output logic       txd1,
  output logic       txd2
);

  // Bit periods in clk cycles for each baud select value, fixed at elaboration.
  localparam int DIV_19200 = CLK_HZ / 19200;
  localparam int DIV_9600  = CLK_HZ / 9600;
  localparam int DIV_4800  = CLK_HZ / 4800;
  localparam int DIV_2400  = CLK_HZ / 2400;
  localparam int DIV_1200  = CLK_HZ / 1200;
  localparam int DIV_600   = CLK_HZ / 600;
  localparam int DIV_300   = CLK_HZ / 300;
  localparam int DIV_75    = CLK_HZ / 75;

  // Counter width must hold the slowest (75 baud) bit period.
  localparam int CW = (DIV_75 < 2) ? 1 : $clog2(DIV_75 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  function automatic logic [CW-1:0] div_lookup(input logic [2:0] sel);
    logic [CW-1:0] d;
    case (sel)
      3'd0:    d = CW'(DIV_19200);
      3'd1:    d = CW'(DIV_9600);
      3'd2:    d = CW'(DIV_4800);
      3'd3:    d = CW'(DIV_2400);
      3'd4:    d = CW'(DIV_1200);
      3'd5:    d = CW'(DIV_600);
      3'd6:    d = CW'(DIV_300);
      default: d = CW'(DIV_75);
    endcase
    return d;
  endfunction

  state_t        state_reg, state_next;
  logic [5:0]    tctrl_reg, tctrl_next;
  logic [7:0]    hold_reg, hold_next;
  logic          full_reg, full_next;
  logic [7:0]    shift_reg, shift_next;
  logic          port_reg, port_next;
  logic [CW-1:0] div_reg, div_next;
  logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic          txd1_reg, txd1_next;
  logic          txd2_reg, txd2_next;

  logic handshake;
  logic baud_done;
  logic stop_done;
  logic frame_start;
  logic accept;
  logic line_bit_next;

  // TCTRL bits 7:6 have no function in this block.
  logic unused_tctrl;
  assign unused_tctrl = ^tctrl_din[7:6];

  // Frame start decision, holding register update and bit sequencing.
  always_comb begin
    state_next    = state_reg;
    tctrl_next    = tctrl_reg;
    hold_next     = hold_reg;
    full_next     = full_reg;
    shift_next    = shift_reg;
    port_next     = port_reg;
    div_next      = div_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    line_bit_next = 1'b1;
    txd1_next     = 1'b1;
    txd2_next     = 1'b1;

    handshake = tctrl_reg[3] ? ser2_cts : ser1_dtr;
    baud_done = (baud_cnt_reg == div_reg - CW'(1));
    stop_done = (state_reg == S_STOP) && baud_done && (bit_cnt_reg == 4'd1);
    // A new frame may start from idle or directly after the last stop-bit cycle.
    frame_start = full_reg && ((state_reg == S_IDLE) || stop_done) &&
                  (tctrl_reg[5:4] == 2'b00) && handshake;
    // The holding register is freed by a frame start in the same cycle.
    accept = tx_we && (!full_reg || frame_start);

    if (tctrl_we) begin
      tctrl_next = tctrl_din[5:0];
    end

    if (accept) begin
      hold_next = tx_din;
      full_next = 1'b1;
    end else if (frame_start) begin
      full_next = 1'b0;
    end

    case (state_reg)
      S_START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_cnt_next  = 4'd0;
          state_next    = S_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_cnt_reg == 4'd7) begin
            bit_cnt_next = 4'd0;
            state_next   = S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == 4'd1) begin
            bit_cnt_next = 4'd0;
            state_next   = S_IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      default: begin
      end
    endcase

    // Port and bit period are frozen per frame so TCTRL writes only affect the next one.
    if (frame_start) begin
      state_next    = S_START;
      shift_next    = hold_reg;
      port_next     = tctrl_reg[3];
      div_next      = div_lookup(tctrl_reg[2:0]);
      baud_cnt_next = '0;
      bit_cnt_next  = 4'd0;
    end

    // Line levels are computed from the next state so the pins are registered.
    case (state_next)
      S_START: line_bit_next = 1'b0;
      S_DATA:  line_bit_next = shift_next[0];
      default: line_bit_next = 1'b1;
    endcase
    if (state_next != S_IDLE) begin
      if (port_next) begin
        txd2_next = line_bit_next;
      end else begin
        txd1_next = line_bit_next;
      end
    end
  end

  // State register; reset aborts any frame and returns both lines high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      tctrl_reg    <= 6'd0;
      hold_reg     <= 8'd0;
      full_reg     <= 1'b0;
      shift_reg    <= 8'd0;
      port_reg     <= 1'b0;
      div_reg      <= CW'(DIV_19200);
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= 4'd0;
      txd1_reg     <= 1'b1;
      txd2_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      tctrl_reg    <= tctrl_next;
      hold_reg     <= hold_next;
      full_reg     <= full_next;
      shift_reg    <= shift_next;
      port_reg     <= port_next;
      div_reg      <= div_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      txd1_reg     <= txd1_next;
      txd2_reg     <= txd2_next;
    end
  end

  assign tx_full   = full_reg;
  assign tx_active = (state_reg != S_IDLE);
  assign txd1      = txd1_reg;
  assign txd2      = txd2_reg;

endmodule

// File: tb/tb_zx8302_sertx.sv
// Bench for zx8302_sertx: a step table for the first frame, hand-written
// sequences for the corner cases, and a per-line frame decoder that checks
// every transmitted frame bit-for-bit against a scoreboard queue.
module tb_zx8302_sertx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tctrl_we = 1'b0;
  logic [7:0] tctrl_din = 8'h00;
  logic       tx_we = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic       ser1_dtr = 1'b1;
  logic       ser2_cts = 1'b1;
  logic       tx_full;
  logic       tx_active;
  logic       txd1;
  logic       txd2;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit       line;   // 0 = txd1, 1 = txd2
    bit [7:0] data;
    int       div;
    bit       abort;  // frame is expected to be cut short by reset
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    int   cyc;
    logic full;
    logic act;
    logic t1;
    logic t2;
  } vec_t;

  zx8302_sertx #(.CLK_HZ(192000)) dut (
    .clk       (clk),
    .reset     (reset),
    .tctrl_we  (tctrl_we),
    .tctrl_din (tctrl_din),
    .tx_we     (tx_we),
    .tx_din    (tx_din),
    .ser1_dtr  (ser1_dtr),
    .ser2_cts  (ser2_cts),
    .tx_full   (tx_full),
    .tx_active (tx_active),
    .txd1      (txd1),
    .txd2      (txd2)
  );

  always #5 clk = ~clk;

  // Advance n cycles, ending 1 time unit after the clock edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_we = 1'b1;
    tx_din = d;
    tick(1);
    tx_we = 1'b0;
  endtask

  task automatic tctrl_write(input logic [7:0] d);
    tctrl_we = 1'b1;
    tctrl_din = d;
    tick(1);
    tctrl_we = 1'b0;
  endtask

  task automatic push_exp(input bit line, input bit [7:0] data, input int div, input bit abort);
    sb_t e;
    e.line = line;
    e.data = data;
    e.div = div;
    e.abort = abort;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((tx_active || tx_full) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, {30'd0, tx_active, tx_full}, 32'd0);
  endtask

  // Frame decoder for one line: on a falling edge, pop the expected frame
  // and check every cycle of all 11 bits plus the idle level of the other line.
  task automatic monitor(input bit line);
    logic prev, cur, other, exp_bit, got_bad;
    sb_t  e;
    bit   bad, aborted;
    int   bad_bit;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = line ? txd2 : txd1;
      if (!reset && prev === 1'b1 && cur === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL frame_unexpected txd%0d: got start bit, required no frame", line + 1);
        end else begin
          e = sb_q.pop_front();
          bad = 1'b0;
          aborted = 1'b0;
          bad_bit = -1;
          got_bad = 1'b1;
          for (int b = 0; b < 11; b++) begin
            exp_bit = (b == 0) ? 1'b0 : (b >= 9) ? 1'b1 : e.data[b-1];
            for (int c = 0; c < e.div; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (reset) begin
                aborted = 1'b1;
                break;
              end
              cur = line ? txd2 : txd1;
              other = line ? txd1 : txd2;
              if (!bad && (cur !== exp_bit || other !== 1'b1)) begin
                bad = 1'b1;
                bad_bit = b;
                got_bad = cur;
              end
            end
            if (aborted) break;
          end
          n_total++;
          if (bad || aborted != e.abort || e.line != line) begin
            $display("FAIL frame txd%0d: got bit %0d level %b aborted %0d, required data %02h div %0d on txd%0d aborted %0d",
                     line + 1, bad_bit, got_bad, aborted, e.data, e.div, e.line + 1, e.abort);
          end else begin
            n_pass++;
            if (aborted) $display("frame txd%0d data %02h aborted by reset as required", line + 1, e.data);
            else $display("frame txd%0d data %02h div %0d ok", line + 1, e.data, e.div);
          end
        end
        cur = 1'b1;
      end
      prev = cur;
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    int cur;

    vecs = '{
      '{0,   1'b1, 1'b0, 1'b1, 1'b1},
      '{1,   1'b0, 1'b1, 1'b0, 1'b1},
      '{10,  1'b0, 1'b1, 1'b0, 1'b1},
      '{11,  1'b0, 1'b1, 1'b1, 1'b1},
      '{20,  1'b0, 1'b1, 1'b1, 1'b1},
      '{21,  1'b0, 1'b1, 1'b0, 1'b1},
      '{31,  1'b0, 1'b1, 1'b1, 1'b1},
      '{41,  1'b0, 1'b1, 1'b0, 1'b1},
      '{51,  1'b0, 1'b1, 1'b0, 1'b1},
      '{61,  1'b0, 1'b1, 1'b1, 1'b1},
      '{71,  1'b0, 1'b1, 1'b0, 1'b1},
      '{81,  1'b0, 1'b1, 1'b1, 1'b1},
      '{91,  1'b0, 1'b1, 1'b1, 1'b1},
      '{110, 1'b0, 1'b1, 1'b1, 1'b1},
      '{111, 1'b0, 1'b0, 1'b1, 1'b1}
    };

    // Reset state
    tick(3);
    reset = 1'b0;
    chk("rst_full", tx_full, 1'b0);
    chk("rst_active", tx_active, 1'b0);
    chk("rst_txd1", txd1, 1'b1);
    chk("rst_txd2", txd2, 1'b1);

    // 1: single frame 0xA5 on SER1, step table
    push_exp(1'b0, 8'hA5, 10, 1'b0);
    tx_write(8'hA5);
    cur = 0;
    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].cyc - cur);
      cur = vecs[i].cyc;
      chk($sformatf("t1_full@%0d", cur), tx_full, vecs[i].full);
      chk($sformatf("t1_active@%0d", cur), tx_active, vecs[i].act);
      chk($sformatf("t1_txd1@%0d", cur), txd1, vecs[i].t1);
      chk($sformatf("t1_txd2@%0d", cur), txd2, vecs[i].t2);
    end
    tick(5);

    // 2: back-to-back frames, write while full ignored
    push_exp(1'b0, 8'h55, 10, 1'b0);
    tx_write(8'h55);
    tick(19);
    push_exp(1'b0, 8'h0F, 10, 1'b0);
    tx_write(8'h0F);
    tick(29);
    tx_write(8'hEE);
    chk("t2_full_after_ignored", tx_full, 1'b1);
    tick(60);
    chk("t2_full@110", tx_full, 1'b1);
    chk("t2_active@110", tx_active, 1'b1);
    chk("t2_txd1@110", txd1, 1'b1);
    tick(1);
    chk("t2_full@111", tx_full, 1'b0);
    chk("t2_active@111", tx_active, 1'b1);
    chk("t2_txd1@111", txd1, 1'b0);
    tick(109);
    chk("t2_active@220", tx_active, 1'b1);
    tick(1);
    chk("t2_active@221", tx_active, 1'b0);
    tick(10);
    chk("t2_full_end", tx_full, 1'b0);

    // 3: 75 baud on SER2, held off by CTS
    ser2_cts = 1'b0;
    tctrl_write(8'h0F);
    push_exp(1'b1, 8'h81, 2560, 1'b0);
    tx_write(8'h81);
    tick(50);
    chk("t3_full_blocked", tx_full, 1'b1);
    chk("t3_active_blocked", tx_active, 1'b0);
    chk("t3_txd2_blocked", txd2, 1'b1);
    ser2_cts = 1'b1;
    tick(1);
    chk("t3_active_start", tx_active, 1'b1);
    chk("t3_txd2_start", txd2, 1'b0);
    chk("t3_full_start", tx_full, 1'b0);
    chk("t3_txd1_start", txd1, 1'b1);
    tick(28159);
    chk("t3_active_last", tx_active, 1'b1);
    tick(1);
    chk("t3_active_end", tx_active, 1'b0);
    chk("t3_txd2_end", txd2, 1'b1);

    // 4: TCTRL write mid-frame takes effect on the next frame
    tctrl_write(8'h00);
    push_exp(1'b0, 8'h3C, 10, 1'b0);
    tx_write(8'h3C);
    tick(29);
    tctrl_write(8'h07);
    push_exp(1'b0, 8'hC3, 2560, 1'b0);
    tx_write(8'hC3);
    chk("t4_full", tx_full, 1'b1);
    wait_idle("t4_idle", 30000);

    // 5: reset during data bit 3 of a SER2 frame, then SER1 frame from reset TCTRL
    tctrl_write(8'h08);
    push_exp(1'b1, 8'h96, 10, 1'b1);
    tx_write(8'h96);
    tick(44);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_txd2", txd2, 1'b1);
    chk("t5_txd1", txd1, 1'b1);
    chk("t5_active", tx_active, 1'b0);
    chk("t5_full", tx_full, 1'b0);
    push_exp(1'b0, 8'h6B, 10, 1'b0);
    tx_write(8'h6B);
    wait_idle("t5_idle", 300);

    // 6: network mode blocks; switching to serial starts the frame,
    // with a data write accepted on the frame-start edge
    tctrl_write(8'h10);
    push_exp(1'b0, 8'hD2, 10, 1'b0);
    tx_write(8'hD2);
    tick(40);
    chk("t6_full_blocked", tx_full, 1'b1);
    chk("t6_active_blocked", tx_active, 1'b0);
    chk("t6_txd1_blocked", txd1, 1'b1);
    tctrl_write(8'h00);
    push_exp(1'b0, 8'h4D, 10, 1'b0);
    tx_write(8'h4D);
    chk("t6_full_same_cycle", tx_full, 1'b1);
    chk("t6_active_start", tx_active, 1'b1);
    chk("t6_txd1_start", txd1, 1'b0);
    wait_idle("t6_idle", 400);

    tick(5);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/zx8302_sertx.md
Name: zx8302_sertx

Overview:
- Serial transmit stage of the ZX8302, driven by the CPU register write decode of the ZX8302 block.
- Takes the transmit-control register (TCTRL, 0x18002) and the transmit-data register (0x18022) writes, and serialises bytes onto SER1 or SER2.
- Holds one byte in a holding register and one in a shift register, with hardware handshake.
- Returns "transmit buffer full" for bit 1 of the ZX8302 status register.

Parameters:
- CLK_HZ, 21000000, frequency of clk in Hz; the baud divider is derived from it.

Ports:
- clk  input  1  system clock; all logic on posedge; the only clock.
- reset  input  1  synchronous, active-high reset.
- tctrl_we  input  1  one-cycle strobe: CPU writes TCTRL.
- tctrl_din  input  8  TCTRL data: [2:0] baud select, [3] port (0=SER1, 1=SER2), [5:4] mode (00=serial), [7:6] ignored.
- tx_we  input  1  one-cycle strobe: CPU writes transmit data.
- tx_din  input  8  byte to transmit.
- ser1_dtr  input  1  SER1 peer ready (1=ready).
- ser2_cts  input  1  SER2 peer ready (1=ready).
- tx_full  output  1  holding register occupied; feeds status bit 1.
- tx_active  output  1  a frame is being shifted out.
- txd1  output  1  SER1 serial data, idle high.
- txd2  output  1  SER2 serial data, idle high.

Behaviour:

Reset:
- tctrl=0x00 (19200 baud, SER1, serial mode), tx_full=0, tx_active=0, txd1=1, txd2=1.
- Holding register, shift register, bit counter and baud counter are all cleared.
- Reset mid-frame aborts the frame; lines return high on the next cycle.

TCTRL:
- tctrl_we latches tctrl_din[5:0] on that edge.
- Baud select maps 0..7 to 19200, 9600, 4800, 2400, 1200, 600, 300, 75.
- Divider DIV = CLK_HZ / baud, integer truncated. DIV is computed as a constant table from CLK_HZ, not with a run-time divider.
- Port, mode and DIV are copied into frame registers at frame start. A TCTRL write mid-frame affects only the next frame.
- If mode != 00 at frame start, no frame starts and the holding register stays full (network/MDV modes are not handled here).

Holding register:
- tx_we with tx_full=0: byte stored, tx_full=1 from the next cycle.
- tx_we with tx_full=1: write ignored, holding contents unchanged.
- Frame start condition: tx_full=1, tx_active=0, mode=00, and the selected handshake is 1 (ser1_dtr for SER1, ser2_cts for SER2).
- On frame start: byte moves to the shift register, tx_full=0 and tx_active=1 from the next cycle, and the start bit drives the selected line from that same cycle.
- tx_we in the same cycle as a frame start: the new byte is accepted, so tx_full stays 1.

Frame:
- 1 start bit (0), 8 data bits LSB first, 2 stop bits (1). 11 bits total, each held exactly DIV clk cycles.
- Frame length is 11*DIV cycles. tx_active falls on the cycle after the last stop-bit cycle.
- Back-to-back frames: if the start condition holds on that cycle, the next start bit follows immediately with no idle gap.
- The unselected line stays 1 throughout.

Handshake:
- Sampled only at frame start. Dropping it mid-frame does not abort the frame.

State machine (counter-based acceptable):
- IDLE -> START (start condition met).
- START -> DATA after DIV cycles.
- DATA repeats for bits 0..7, DIV cycles each.
- DATA -> STOP after bit 7; STOP lasts 2*DIV cycles.
- STOP -> IDLE, or directly to START if the start condition holds.

Widths:
- Baud counter is wide enough for DIV at 75 baud; at least 19 bits for the default CLK_HZ (280000 cycles).
- Bit counter is 4 bits.

Test Plan:
Bench uses CLK_HZ=192000, giving DIV=10 at 19200 baud and DIV=2560 at 75 baud.

1. Reset, ser1_dtr=1, tx_we with 0xA5 -> tx_full=1 for one cycle, then txd1 shows 0,1,0,1,0,0,1,0,1,1,1 with 10 cycles per bit; txd2 stays 1; tx_active drops after 110 cycles.
2. Two writes 0x55 then 0x0F (second written during frame 1) -> tx_full=1 until frame 1 ends; frames are contiguous (220 cycles, no gap); a third write while full is ignored and never transmitted.
3. TCTRL=0x0F (75 baud, SER2), ser2_cts=0, write 0x81 -> nothing transmitted and tx_full stays 1; raise ser2_cts -> frame on txd2 with 2560 cycles per bit; txd1 stays 1.
4. Start a frame at 19200, write TCTRL=0x07 mid-frame -> current frame finishes at 10 cycles/bit; next frame uses 2560 cycles/bit.
5. Assert reset during data bit 3 -> txd1=1, tx_active=0, tx_full=0 on the next cycle; a subsequent write transmits correctly.
6. TCTRL=0x10 (network mode), write a byte -> no output and tx_full remains 1; TCTRL=0x00 -> frame starts on SER1.
